// File: rtl/eval_stack_arbiter_pkg.sv
// Shared definitions for the evaluation-stack arbiter: FSM state encoding,
// stack-op and requester encodings, and a one-hot helper.
package bali_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic OP_PUSH   = 1'b1;
  localparam logic OP_POP    = 1'b0;
  localparam logic REQ_CTRL  = 1'b0;
  localparam logic REQ_FRAME = 1'b1;

  // Turn a requester index into its one-hot grant/done vector
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/eval_stack_arbiter_rr_arb2.sv
// Two-way winner select for the eval-stack arbiter.
// Build option BALI_ARB_ROUND_ROBIN_EN: when defined, ties alternate by
// favouring the requester not served last; otherwise requester 0 wins ties.
module rr_arb2
  import bali_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic       win
);

  logic last_grant_r;

  // Remember the requester served by the most recently completed transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
    end else if (upd) begin
      last_grant_r <= upd_idx;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

`ifdef BALI_ARB_ROUND_ROBIN_EN
  // Ties go to the requester that was not served last; singles win outright
  always_comb begin
    win = REQ_CTRL;
    if (req[0] && req[1]) begin
      win = ~last_grant_r;
    end else if (req[1]) begin
      win = REQ_FRAME;
    end else begin
      win = REQ_CTRL;
    end
  end
`else
  // Fixed priority leaves the served-last history without a consumer
  logic unused_s;
  assign unused_s = last_grant_r;

  // Requester 0 always wins ties; requester 1 wins only when alone
  always_comb begin
    win = REQ_CTRL;
    if (req[0]) begin
      win = REQ_CTRL;
    end else if (req[1]) begin
      win = REQ_FRAME;
    end else begin
      win = REQ_CTRL;
    end
  end
`endif

endmodule

// File: rtl/eval_stack_arbiter.sv
// Shares the single evaluation-stack port between the bytecode control unit
// (requester 0) and the frame/invoke unit (requester 1). Serialises push/pop
// transactions, tracks occupancy and rejects overflow/underflow locally.
// Build option BALI_ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
module eval_stack_arbiter
  import bali_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [1:0]            push,
  input  logic [1:0][DATA_W-1:0] wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic                  err,
  output logic [DATA_W-1:0]     rdata,
  output logic [CNT_W-1:0]      depth,
  output logic                  evalpush,
  output logic [DATA_W-1:0]     evalwrite,
  output logic                  evaltrigger,
  input  logic [DATA_W-1:0]     evalread,
  input  logic                  evaldone
);

  localparam logic [CNT_W-1:0] DEPTH_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] DEPTH_ONE  = CNT_W'(1);

  arb_state_t        state_r, state_nxt_s;
  logic [1:0]        gnt_r, gnt_nxt_s;
  logic [1:0]        done_r, done_nxt_s;
  logic              err_r, err_nxt_s;
  logic [DATA_W-1:0] rdata_r, rdata_nxt_s;
  logic [CNT_W-1:0]  depth_r, depth_nxt_s;
  logic              evalpush_r, evalpush_nxt_s;
  logic [DATA_W-1:0] evalwrite_r, evalwrite_nxt_s;
  logic              evaltrigger_r, evaltrigger_nxt_s;
  logic              win_r, win_nxt_s;
  logic              legal_r, legal_nxt_s;
  logic              arb_win_s;
  logic              rr_upd_s;

  // Served-last history advances as each transaction completes
  assign rr_upd_s = (state_r == RESP);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .upd     (rr_upd_s),
    .upd_idx (win_r),
    .win     (arb_win_s)
  );

  // State and registered outputs; reset empties the stack view and aborts any op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      gnt_r         <= 2'b00;
      done_r        <= 2'b00;
      err_r         <= 1'b0;
      rdata_r       <= {DATA_W{1'b0}};
      depth_r       <= DEPTH_ZERO;
      evalpush_r    <= 1'b0;
      evalwrite_r   <= {DATA_W{1'b0}};
      evaltrigger_r <= 1'b0;
      win_r         <= 1'b0;
      legal_r       <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      gnt_r         <= gnt_nxt_s;
      done_r        <= done_nxt_s;
      err_r         <= err_nxt_s;
      rdata_r       <= rdata_nxt_s;
      depth_r       <= depth_nxt_s;
      evalpush_r    <= evalpush_nxt_s;
      evalwrite_r   <= evalwrite_nxt_s;
      evaltrigger_r <= evaltrigger_nxt_s;
      win_r         <= win_nxt_s;
      legal_r       <= legal_nxt_s;
    end
  end

  // Next-state sequencing: accept, issue or reject, wait for stack, respond
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (|req) state_nxt_s = ISSUE;
        else      state_nxt_s = IDLE;
      end
      ISSUE: begin
        if (legal_r) state_nxt_s = WAIT;
        else         state_nxt_s = RESP;
      end
      WAIT: begin
        if (evaldone) state_nxt_s = RESP;
        else          state_nxt_s = WAIT;
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs; legality is decided at accept time
  // so that the stack trigger can be a registered pulse during ISSUE
  always_comb begin
    gnt_nxt_s         = gnt_r;
    done_nxt_s        = 2'b00;
    err_nxt_s         = 1'b0;
    rdata_nxt_s       = rdata_r;
    depth_nxt_s       = depth_r;
    evalpush_nxt_s    = evalpush_r;
    evalwrite_nxt_s   = evalwrite_r;
    evaltrigger_nxt_s = 1'b0;
    win_nxt_s         = win_r;
    legal_nxt_s       = legal_r;
    case (state_r)
      IDLE: begin
        if (|req) begin
          win_nxt_s       = arb_win_s;
          gnt_nxt_s       = idx_to_onehot(arb_win_s);
          evalpush_nxt_s  = push[arb_win_s];
          evalwrite_nxt_s = wdata[arb_win_s];
          if (push[arb_win_s] == OP_PUSH) begin
            legal_nxt_s = (depth_r < DEPTH_FULL);
          end else begin
            legal_nxt_s = (depth_r > DEPTH_ZERO);
          end
          evaltrigger_nxt_s = legal_nxt_s;
        end else begin
          gnt_nxt_s = 2'b00;
        end
      end
      ISSUE: begin
        if (!legal_r) begin
          done_nxt_s = idx_to_onehot(win_r);
          err_nxt_s  = 1'b1;
        end else begin
          done_nxt_s = 2'b00;
          err_nxt_s  = 1'b0;
        end
      end
      WAIT: begin
        if (evaldone) begin
          done_nxt_s = idx_to_onehot(win_r);
          if (evalpush_r == OP_POP) begin
            rdata_nxt_s = evalread;
            depth_nxt_s = depth_r - DEPTH_ONE;
          end else begin
            depth_nxt_s = depth_r + DEPTH_ONE;
          end
        end else begin
          done_nxt_s = 2'b00;
        end
      end
      RESP: begin
        gnt_nxt_s = 2'b00;
      end
      default: begin
        gnt_nxt_s = 2'b00;
      end
    endcase
  end

  assign gnt         = gnt_r;
  assign done        = done_r;
  assign err         = err_r;
  assign rdata       = rdata_r;
  assign depth       = depth_r;
  assign evalpush    = evalpush_r;
  assign evalwrite   = evalwrite_r;
  assign evaltrigger = evaltrigger_r;

endmodule

// File: tb/tb_eval_stack_arbiter.sv
// Self-checking bench for eval_stack_arbiter with a behavioural stack model
// and a scoreboard of expected completions.
module tb_eval_stack_arbiter;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [1:0]             req;
  logic [1:0]             push;
  logic [1:0][DATA_W-1:0] wdata;
  logic [1:0]             gnt;
  logic [1:0]             done;
  logic                   err;
  logic [DATA_W-1:0]      rdata;
  logic [CNT_W-1:0]       depth;
  logic                   evalpush;
  logic [DATA_W-1:0]      evalwrite;
  logic                   evaltrigger;
  logic [DATA_W-1:0]      evalread;
  logic                   evaldone;

  always #5 clk = ~clk;

  eval_stack_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .push        (push),
    .wdata       (wdata),
    .gnt         (gnt),
    .done        (done),
    .err         (err),
    .rdata       (rdata),
    .depth       (depth),
    .evalpush    (evalpush),
    .evalwrite   (evalwrite),
    .evaltrigger (evaltrigger),
    .evalread    (evalread),
    .evaldone    (evaldone)
  );

  typedef struct {
    logic        who;
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
    int          dep;
  } exp_t;

  typedef struct {
    logic        who;
    logic        op;
    logic [31:0] data;
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
    int          dep;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[8];
  int          total = 0;
  int          bad = 0;
  int          trig_cnt = 0;
  logic [31:0] mem[0:127];
  int          sp = 0;
  int          stk_lat = 1;
  int          rst_gen = 0;

  // Behavioural stack: answers each trigger stk_lat cycles later
  initial begin
    logic        op;
    logic [31:0] d;
    int          g;
    evaldone = 1'b0;
    evalread = 32'd0;
    forever begin
      @(negedge clk);
      if (evaltrigger === 1'b1) begin
        g  = rst_gen;
        op = evalpush;
        d  = evalwrite;
        repeat (stk_lat) @(posedge clk);
        #1;
        if (g == rst_gen) begin
          if (op) begin
            mem[sp] = d;
            sp++;
          end else begin
            sp--;
            evalread = mem[sp];
          end
        end
        evaldone = 1'b1;
        @(posedge clk);
        #1 evaldone = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_done();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("unexpected_done", 64'(done), 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk("done_onehot", 64'(done), 64'(e.who ? 2'b10 : 2'b01));
      chk("gnt_with_done", 64'(gnt), 64'(e.who ? 2'b10 : 2'b01));
      chk("err", 64'(err), 64'(e.err));
      chk("depth", 64'(depth), 64'(e.dep));
      if (e.chk_rd) chk("rdata", 64'(rdata), 64'(e.rd));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (evaltrigger === 1'b1) trig_cnt++;
    if (done !== 2'b00) check_done();
  endtask

  task automatic wait_sb(input string name, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_pending"}, 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  function automatic vec_t mk(input logic who, input logic op, input logic [31:0] d,
                              input logic e, input logic c, input logic [31:0] rd,
                              input int dep);
    vec_t v;
    v.who = who; v.op = op; v.data = d; v.err = e; v.chk_rd = c; v.rd = rd; v.dep = dep;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    exp_t e;
    int   t0;
    e.who = v.who; e.err = v.err; e.chk_rd = v.chk_rd; e.rd = v.rd; e.dep = v.dep;
    sb_q.push_back(e);
    t0 = trig_cnt;
    req[v.who]   = 1'b1;
    push[v.who]  = v.op;
    wdata[v.who] = v.data;
    wait_sb("txn", 40);
    req[v.who] = 1'b0;
    chk("trig_count", 64'(trig_cnt - t0), v.err ? 64'd0 : 64'd1);
    tick();
  endtask

  initial begin
    exp_t e;
    int   n;

    vecs[0] = mk(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0,        1);
    vecs[1] = mk(1'b0, 1'b1, 32'd2,         1'b0, 1'b0, 32'd0,        2);
    vecs[2] = mk(1'b0, 1'b0, 32'd0,         1'b0, 1'b1, 32'd2,        1);
    vecs[3] = mk(1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 32'hFFFF_FFFF, 0);
    vecs[4] = mk(1'b0, 1'b0, 32'd0,         1'b1, 1'b0, 32'd0,        0);
    vecs[5] = mk(1'b1, 1'b0, 32'd0,         1'b1, 1'b0, 32'd0,        0);
    vecs[6] = mk(1'b1, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'd0,        1);
    vecs[7] = mk(1'b0, 1'b0, 32'd0,         1'b0, 1'b1, 32'h0000_1234, 0);

    req = 2'b00; push = 2'b00; wdata = '0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_depth", 64'(depth), 64'd0);
    chk("rst_trig", 64'(evaltrigger), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_evalpush", 64'(evalpush), 64'd0);
    chk("rst_evalwrite", 64'(evalwrite), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // rejected pop: grant in N+1 without trigger, done+err in N+2
    e.who = 1'b0; e.err = 1'b1; e.chk_rd = 1'b0; e.rd = 32'd0; e.dep = 0;
    sb_q.push_back(e);
    req[0] = 1'b1; push[0] = 1'b0;
    tick();
    chk("rej_gnt_n1", 64'(gnt), 64'd1);
    chk("rej_trig_n1", 64'(evaltrigger), 64'd0);
    tick();
    chk("rej_done_n2", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    req[0] = 1'b0;
    tick();

    // legal push: trigger in N+1, stack answers in N+2, done in N+3
    stk_lat = 1;
    e.who = 1'b1; e.err = 1'b0; e.chk_rd = 1'b0; e.rd = 32'd0; e.dep = 1;
    sb_q.push_back(e);
    req[1] = 1'b1; push[1] = 1'b1; wdata[1] = 32'h0000_CAFE;
    tick();
    chk("push_trig_n1", 64'(evaltrigger), 64'd1);
    chk("push_gnt_n1", 64'(gnt), 64'd2);
    chk("push_evalwrite", 64'(evalwrite), 64'h0000_CAFE);
    tick();
    chk("push_not_early", 64'(sb_q.size()), 64'd1);
    tick();
    chk("push_done_n3", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    req[1] = 1'b0;
    tick();
    run_txn(mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_CAFE, 0));

    // fill to capacity, then one push too many
    for (int i = 0; i < DEPTH; i++) run_txn(mk(1'b0, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 32'd0, i + 1));
    run_txn(mk(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0, DEPTH));
    chk("full_depth", 64'(depth), 64'(DEPTH));
    run_txn(mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h100 + 32'(DEPTH - 1), DEPTH - 1));

    // reset while the stack is still working on a push
    stk_lat = 6;
    req[0] = 1'b1; push[0] = 1'b1; wdata[0] = 32'd77;
    tick();
    chk("rst_mid_trig", 64'(evaltrigger), 64'd1);
    tick();
    rst_n = 1'b0;
    rst_gen++;
    #1;
    chk("rst_mid_gnt", 64'(gnt), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_trig0", 64'(evaltrigger), 64'd0);
    chk("rst_mid_depth", 64'(depth), 64'd0);
    req[0] = 1'b0;
    sp = 0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("late_done_depth", 64'(depth), 64'd0);
    chk("late_done_gnt", 64'(gnt), 64'd0);
    stk_lat = 1;

    // both requesters contend for four transactions
    for (int k = 0; k < 4; k++) begin
`ifdef BALI_ARB_ROUND_ROBIN_EN
      e.who = (k % 2 == 1);
`else
      e.who = 1'b0;
`endif
      e.err = 1'b0; e.chk_rd = 1'b0; e.rd = 32'd0; e.dep = k + 1;
      sb_q.push_back(e);
    end
    push = 2'b11; wdata[0] = 32'h0000_00A0; wdata[1] = 32'h0000_00B1;
    req = 2'b11;
    wait_sb("arb", 80);
    req = 2'b00;
    tick();
    chk("arb_depth", 64'(depth), 64'd4);

    // requester 1 withdraws its request one cycle after being granted
    e.who = 1'b1; e.err = 1'b0; e.chk_rd = 1'b0; e.rd = 32'd0; e.dep = 5;
    sb_q.push_back(e);
    req[1] = 1'b1; push[1] = 1'b1; wdata[1] = 32'h0000_0055;
    n = 0;
    while (gnt[1] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("drop_gnt_seen", 64'(gnt[1]), 64'd1);
    tick();
    req[1] = 1'b0;
    wait_sb("drop", 40);
    tick();
    run_txn(mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0055, 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
